// File: rtl/alu_issue_queue_if.sv
// Request, ALU-drive and result-strobe bundle for alu_issue_queue.
// slave = queue side, master = requester / ALU-consumer side.
interface alu_issue_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int TAG_WIDTH  = 4
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_mode;
  logic [CMD_WIDTH-1:0]  req_cmd;
  logic [DATA_WIDTH-1:0] req_opa;
  logic [DATA_WIDTH-1:0] req_opb;
  logic                  req_cin;
  logic [1:0]            req_in_valid;
  logic [TAG_WIDTH-1:0]  acc_tag;
  logic                  alu_ce;
  logic                  alu_mode;
  logic [CMD_WIDTH-1:0]  alu_cmd;
  logic [DATA_WIDTH-1:0] alu_opa;
  logic [DATA_WIDTH-1:0] alu_opb;
  logic                  alu_cin;
  logic [1:0]            alu_in_valid;
  logic                  res_valid;
  logic [TAG_WIDTH-1:0]  res_tag;
  logic                  busy;

  modport slave (
    input  req_valid, req_mode, req_cmd,
    input  req_opa, req_opb, req_cin,
    input  req_in_valid,
    output req_ready, acc_tag, alu_ce,
    output alu_mode, alu_cmd, alu_opa,
    output alu_opb, alu_cin, alu_in_valid,
    output res_valid, res_tag, busy
  );

  modport master (
    output req_valid, req_mode, req_cmd,
    output req_opa, req_opb, req_cin,
    output req_in_valid,
    input  req_ready, acc_tag, alu_ce,
    input  alu_mode, alu_cmd, alu_opa,
    input  alu_opb, alu_cin, alu_in_valid,
    input  res_valid, res_tag, busy
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Tagged request FIFO feeding the ALU, with a post-multiply idle
// slot and a 3-deep shift tracker that strobes completing tags.
module alu_issue_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  alu_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = 1;

  typedef struct packed {
    logic                  mode;
    logic [CMD_WIDTH-1:0]  cmd;
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic                  cin;
    logic [1:0]            iv;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [AW:0]          r_wptr, r_rptr;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_bubble;

  logic                  r_alu_mode;
  logic [CMD_WIDTH-1:0]  r_alu_cmd;
  logic [DATA_WIDTH-1:0] r_alu_opa;
  logic [DATA_WIDTH-1:0] r_alu_opb;
  logic                  r_alu_cin;
  logic [1:0]            r_alu_iv;

  logic                 r_t1_v, r_t2_v, r_t3_v;
  logic [TAG_WIDTH-1:0] r_t1_tag, r_t2_tag, r_t3_tag;
  logic                 r_res_valid;
  logic [TAG_WIDTH-1:0] r_res_tag;

  logic   w_empty, w_full, w_push, w_pop, w_mul;
  entry_t w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = bus.req_valid && !w_full;
  assign w_pop   = i_en && !w_empty && !r_bubble;
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_mul   = w_head.mode &&
                   (w_head.cmd == CMD_WIDTH'(9) ||
                    w_head.cmd == CMD_WIDTH'(10));

  assign bus.req_ready    = !w_full;
  assign bus.acc_tag      = r_tag;
  assign bus.alu_ce       = i_en;
  assign bus.alu_mode     = r_alu_mode;
  assign bus.alu_cmd      = r_alu_cmd;
  assign bus.alu_opa      = r_alu_opa;
  assign bus.alu_opb      = r_alu_opb;
  assign bus.alu_cin      = r_alu_cin;
  assign bus.alu_in_valid = r_alu_iv;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_tag      = r_res_tag;
  assign bus.busy         = !w_empty || r_t1_v || r_t2_v ||
                            r_t3_v || r_res_valid;

  // Entry storage; contents are don't-care until pointed at.
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= '{
        mode: bus.req_mode, cmd: bus.req_cmd,
        opa: bus.req_opa, opb: bus.req_opb,
        cin: bus.req_cin, iv: bus.req_in_valid,
        tag: r_tag};
  end

  // FIFO pointers and tag counter; pushes ignore EN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_tag  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PONE;
        r_tag  <= r_tag + TAG_WIDTH'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PONE;
    end
  end

  // ALU drive: head entry on issue, no-op on every other EN slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_mode <= 1'b1;
      r_alu_cmd  <= '0;
      r_alu_opa  <= '0;
      r_alu_opb  <= '0;
      r_alu_cin  <= 1'b0;
      r_alu_iv   <= 2'b00;
      r_bubble   <= 1'b0;
    end else if (i_en) begin
      if (w_pop) begin
        r_alu_mode <= w_head.mode;
        r_alu_cmd  <= w_head.cmd;
        r_alu_opa  <= w_head.opa;
        r_alu_opb  <= w_head.opb;
        r_alu_cin  <= w_head.cin;
        r_alu_iv   <= w_head.iv;
        r_bubble   <= w_mul;
      end else begin
        r_alu_mode <= 1'b1;
        r_alu_cmd  <= '0;
        r_alu_opa  <= '0;
        r_alu_opb  <= '0;
        r_alu_cin  <= 1'b0;
        r_alu_iv   <= 2'b00;
        r_bubble   <= 1'b0;
      end
    end
  end

  // Result tracker: shift toward T1, inject at depth matching latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_t1_v      <= 1'b0;
      r_t2_v      <= 1'b0;
      r_t3_v      <= 1'b0;
      r_t1_tag    <= '0;
      r_t2_tag    <= '0;
      r_t3_tag    <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
    end else if (i_en) begin
      r_res_valid <= r_t1_v;
      r_res_tag   <= r_t1_tag;
      r_t1_v      <= r_t2_v;
      r_t1_tag    <= r_t2_tag;
      r_t2_v      <= r_t3_v;
      r_t2_tag    <= r_t3_tag;
      r_t3_v      <= 1'b0;
      r_t3_tag    <= '0;
      if (w_pop && !w_mul) begin
        r_t2_v   <= 1'b1;
        r_t2_tag <= w_head.tag;
      end
      if (w_pop && w_mul) begin
        r_t3_v   <= 1'b1;
        r_t3_tag <= w_head.tag;
      end
    end else begin
      r_res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue against a queue-based
// model of issue cadence, tags and result timing.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  int total = 0;
  int bad   = 0;

  alu_issue_queue_if #(
    .DATA_WIDTH(8), .CMD_WIDTH(4), .TAG_WIDTH(4)
  ) bus ();

  alu_issue_queue #(
    .DATA_WIDTH(8), .CMD_WIDTH(4),
    .DEPTH(4), .TAG_WIDTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode; logic [3:0] cmd;
    logic [7:0] a; logic [7:0] b;
    bit cin; logic [1:0] iv; int tag;
  } req_t;
  typedef struct { int due; int tag; } pend_t;

  req_t  mq[$];
  pend_t pq[$];
  req_t  m_alu;
  req_t  cur;
  int    e_cnt, next_ok, m_tag;
  bit    m_res_valid;
  logic [3:0] m_res_tag;

  function automatic bit is_mul(req_t r);
    return r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10);
  endfunction

  function automatic logic [23:0] pk(req_t r);
    return {r.mode, r.cmd, r.a, r.b, r.cin, r.iv};
  endfunction

  function automatic logic [23:0] dut_alu();
    return {bus.alu_mode, bus.alu_cmd, bus.alu_opa,
            bus.alu_opb, bus.alu_cin, bus.alu_in_valid};
  endfunction

  function automatic req_t noop();
    req_t r;
    r = '{1'b1, 4'd0, 8'd0, 8'd0, 1'b0, 2'b00, 0};
    return r;
  endfunction

  task automatic drive(input bit v, input req_t r);
    cur = r;
    bus.req_valid    = v;
    bus.req_mode     = r.mode;
    bus.req_cmd      = r.cmd;
    bus.req_opa      = r.a;
    bus.req_opb      = r.b;
    bus.req_cin      = r.cin;
    bus.req_in_valid = r.iv;
  endtask

  function automatic req_t rnd(input bit allow_mul);
    req_t r;
    r.mode = 1'($urandom);
    r.cmd  = 4'($urandom);
    if (!allow_mul && r.mode && (r.cmd == 9 || r.cmd == 10))
      r.cmd = 4'd1;
    if (allow_mul && $urandom_range(2) == 0) begin
      r.mode = 1'b1;
      r.cmd  = 4'd9 + 4'($urandom_range(1));
    end
    r.a = 8'($urandom); r.b = 8'($urandom);
    r.cin = 1'($urandom); r.iv = 2'($urandom);
    r.tag = 0;
    return r;
  endfunction

  function automatic req_t mk(bit mo, int c, int a, int b, int iv);
    req_t r;
    r = '{mo, 4'(c), 8'(a), 8'(b), 1'b0, 2'(iv), 0};
    return r;
  endfunction

  task automatic model_clear();
    mq.delete(); pq.delete();
    e_cnt = 0; next_ok = 0; m_tag = 0;
    m_res_valid = 0; m_res_tag = '0;
    m_alu = noop();
  endtask

  task automatic step();
    bit   do_push;
    bit   ml;
    req_t h;
    do_push = bus.req_valid && (mq.size() < 4);
    @(posedge clk);
    if (en) begin
      e_cnt++;
      if (mq.size() > 0 && e_cnt >= next_ok) begin
        h  = mq.pop_front();
        ml = is_mul(h);
        m_alu = h;
        pq.push_back('{e_cnt + (ml ? 3 : 2), h.tag});
        next_ok = e_cnt + (ml ? 2 : 1);
      end else begin
        m_alu = noop();
      end
      m_res_valid = 0;
      m_res_tag   = '0;
      for (int i = 0; i < pq.size(); i++)
        if (pq[i].due == e_cnt) begin
          m_res_valid = 1;
          m_res_tag   = 4'(pq[i].tag);
          pq.delete(i);
          break;
        end
    end else begin
      m_res_valid = 0;
    end
    if (do_push) begin
      h = cur; h.tag = m_tag;
      mq.push_back(h);
      m_tag = (m_tag + 1) % 16;
    end
    #1;
  endtask

  function automatic bit m_busy();
    return mq.size() > 0 || pq.size() > 0 || m_res_valid;
  endfunction

  task automatic do_reset();
    drive(0, noop());
    rst = 1'b1;
    #2;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst && en && dut.w_pop && !dut.w_mul) begin
      total++;
      if (dut.r_t3_v) begin
        bad++;
        $display("FAIL t3_free: t3 valid=%0b want 0", dut.r_t3_v);
      end
    end
  end

  task automatic test_reset();
    en = 1'b1;
    do_reset();
    total += 7;
    if (bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    if (bus.acc_tag !== 4'd0) begin bad++;
      $display("FAIL rst_acc_tag got %0d want 0", bus.acc_tag); end
    if (dut_alu() !== pk(noop())) begin bad++;
      $display("FAIL rst_alu got %h want %h", dut_alu(), pk(noop())); end
    if (bus.res_valid !== 1'b0) begin bad++;
      $display("FAIL rst_res_valid got %b want 0", bus.res_valid); end
    if (bus.res_tag !== 4'd0) begin bad++;
      $display("FAIL rst_res_tag got %0d want 0", bus.res_tag); end
    if (bus.busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy got %b want 0", bus.busy); end
    if (bus.alu_ce !== 1'b1) begin bad++;
      $display("FAIL rst_ce got %b want 1", bus.alu_ce); end
  endtask

  task automatic test_add();
    do_reset();
    drive(1, mk(1, 0, 3, 4, 3));
    step();
    drive(0, noop());
    step();
    total += 2;
    if (dut_alu() !== pk(mk(1, 0, 3, 4, 3))) begin bad++;
      $display("FAIL add_issue got %h want %h",
               dut_alu(), pk(mk(1, 0, 3, 4, 3))); end
    if (bus.res_valid !== 1'b0) begin bad++;
      $display("FAIL add_early got %b want 0", bus.res_valid); end
    step();
    step();
    total += 2;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd0) begin bad++;
      $display("FAIL add_res got v=%b t=%0d want v=1 t=0",
               bus.res_valid, bus.res_tag); end
    if (m_res_valid !== 1'b1) begin bad++;
      $display("FAIL add_model got %b want 1", m_res_valid); end
    step();
    total++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL add_done got v=%b busy=%b want 0 0",
               bus.res_valid, bus.busy); end
  endtask

  task automatic test_mul_bubble();
    int got[$];
    int nres;
    do_reset();
    drive(1, mk(1, 9, 2, 3, 3));
    step();
    drive(1, mk(1, 0, 5, 6, 3));
    step();
    drive(0, noop());
    total++;
    if (bus.alu_cmd !== 4'd9) begin bad++;
      $display("FAIL mul_issue got cmd %0d want 9", bus.alu_cmd); end
    step();
    total++;
    if (bus.alu_in_valid !== 2'b00) begin bad++;
      $display("FAIL mul_bubble got iv %b want 00",
               bus.alu_in_valid); end
    step();
    total++;
    if (dut_alu() !== pk(mk(1, 0, 5, 6, 3))) begin bad++;
      $display("FAIL mul_add got %h want %h",
               dut_alu(), pk(mk(1, 0, 5, 6, 3))); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (bus.res_valid !== m_res_valid ||
          (m_res_valid && bus.res_tag !== m_res_tag)) begin bad++;
        $display("FAIL mul_res c=%0d got v=%b t=%0d want v=%b t=%0d",
                 c, bus.res_valid, bus.res_tag,
                 m_res_valid, m_res_tag); end
      if (bus.res_valid) got.push_back(int'(bus.res_tag));
      step();
    end
    nres = got.size();
    total++;
    if (nres != 2 || got[0] != 0 || got[1] != 1) begin bad++;
      $display("FAIL mul_order got n=%0d want tags 0,1", nres); end
  endtask

  task automatic test_fill_en0();
    int acc;
    int got[$];
    do_reset();
    en = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, rnd(0));
      if (bus.req_ready) acc++;
      step();
      total++;
      if (bus.res_valid !== 1'b0 || bus.alu_ce !== 1'b0) begin bad++;
        $display("FAIL en0_quiet got v=%b ce=%b want 0 0",
                 bus.res_valid, bus.alu_ce); end
    end
    total += 2;
    if (acc != 4) begin bad++;
      $display("FAIL en0_accepts got %0d want 4", acc); end
    if (bus.req_ready !== 1'b0) begin bad++;
      $display("FAIL en0_full got %b want 0", bus.req_ready); end
    drive(0, noop());
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.res_valid) got.push_back(int'(bus.res_tag));
    end
    total++;
    if (got.size() != 4) begin bad++;
      $display("FAIL en0_drain got n=%0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] != i) begin bad++;
        $display("FAIL en0_tag i=%0d got %0d want %0d",
                 i, got[i], i); end
    end
  endtask

  task automatic test_en_gap();
    int got[$];
    do_reset();
    drive(1, rnd(0)); step();
    drive(1, rnd(0)); step();
    drive(0, noop()); step();
    for (int c = 0; c < 9; c++) begin
      en = (c < 2) ? 1'b0 : 1'b1;
      step();
      total++;
      if (bus.res_valid !== m_res_valid ||
          (m_res_valid && bus.res_tag !== m_res_tag)) begin bad++;
        $display("FAIL gap_res c=%0d got v=%b t=%0d want v=%b t=%0d",
                 c, bus.res_valid, bus.res_tag,
                 m_res_valid, m_res_tag); end
      if (bus.res_valid) got.push_back(int'(bus.res_tag));
    end
    total++;
    if (got.size() != 2 || got[0] != 0 || got[1] != 1) begin bad++;
      $display("FAIL gap_order got n=%0d want tags 0,1", got.size()); end
  endtask

  task automatic test_wrap();
    int got[$];
    int acc;
    int cyc;
    do_reset();
    acc = 0;
    cyc = 0;
    while ((acc < 20 || bus.busy) && cyc < 400) begin
      if (acc < 20) drive(1, rnd(1));
      else drive(0, noop());
      if (bus.req_valid && bus.req_ready) acc++;
      step();
      cyc++;
      if (bus.res_valid) got.push_back(int'(bus.res_tag));
    end
    total++;
    if (cyc >= 400 || got.size() != 20) begin bad++;
      $display("FAIL wrap_count got n=%0d cyc=%0d want 20",
               got.size(), cyc); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      total++;
      if (got[i] != i % 16) begin bad++;
        $display("FAIL wrap_tag i=%0d got %0d want %0d",
                 i, got[i], i % 16); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(4) != 0);
      if ($urandom_range(2) != 0) drive(1, rnd(1));
      else drive(0, noop());
      step();
      total++;
      if (bus.res_valid !== m_res_valid ||
          (m_res_valid && bus.res_tag !== m_res_tag) ||
          bus.busy !== m_busy() ||
          bus.req_ready !== (mq.size() < 4) ||
          bus.acc_tag !== 4'(m_tag) ||
          dut_alu() !== pk(m_alu)) begin bad++;
        $display("FAIL rnd c=%0d got v=%b t=%0d b=%b r=%b a=%0d alu=%h want v=%b t=%0d b=%b r=%b a=%0d alu=%h",
                 c, bus.res_valid, bus.res_tag, bus.busy,
                 bus.req_ready, bus.acc_tag, dut_alu(),
                 m_res_valid, m_res_tag, m_busy(),
                 mq.size() < 4, m_tag, pk(m_alu)); end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_flight();
    do_reset();
    drive(1, mk(1, 10, 7, 9, 3)); step();
    drive(0, noop()); step();
    total++;
    if (bus.alu_cmd !== 4'd10) begin bad++;
      $display("FAIL rf_issue got cmd %0d want 10", bus.alu_cmd); end
    step();
    rst = 1'b1;
    #1;
    model_clear();
    total++;
    if (dut_alu() !== pk(noop()) || bus.res_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.acc_tag !== 4'd0 ||
        bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL rf_reset got alu=%h v=%b b=%b a=%0d r=%b",
               dut_alu(), bus.res_valid, bus.busy,
               bus.acc_tag, bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (bus.res_valid !== 1'b0) begin bad++;
        $display("FAIL rf_stale c=%0d got v=%b want 0",
                 c, bus.res_valid); end
    end
    total++;
    if (bus.acc_tag !== 4'd0) begin bad++;
      $display("FAIL rf_tag got %0d want 0", bus.acc_tag); end
  endtask

  initial begin
    drive(0, noop());
    model_clear();
    test_reset();
    test_add();
    test_mul_bubble();
    test_fill_en0();
    test_en_gap();
    test_wrap();
    test_random();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Command staging block directly upstream of the ALU. It buffers operand/command requests in a small FIFO with a valid/ready handshake. Each request is issued to the ALU input ports on a fixed cadence; after every multiply one idle slot is inserted so that 2-cycle and 3-cycle results never land on the same cycle. Each request gets a tag, and a one-cycle RES_VALID/RES_TAG strobe marks the cycle in which its ALU RESULT is new.

## Interface
- DATA_WIDTH, 8, operand width
- CMD_WIDTH, 4, command width
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_WIDTH, 4, request tag width
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  global enable; 0 freezes issue and result tracking
- REQ_VALID  in  1  request present
- REQ_READY  out  1  FIFO not full
- REQ_MODE  in  1  1 = arithmetic, 0 = logical
- REQ_CMD  in  CMD_WIDTH  command
- REQ_OPA, REQ_OPB  in  DATA_WIDTH  operands
- REQ_CIN  in  1  carry in
- REQ_IN_VALID  in  2  operand-valid code
- ACC_TAG  out  TAG_WIDTH  tag given to a request accepted this cycle
- ALU_CE  out  1  ALU clock enable, equal to EN (combinational)
- ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_IN_VALID  out  registered  ALU inputs
- RES_VALID  out  1  one-cycle pulse: ALU RESULT belongs to RES_TAG
- RES_TAG  out  TAG_WIDTH  tag of the completing request
- BUSY  out  1  FIFO non-empty or any result in flight

## Operation
- Push on REQ_VALID & REQ_READY, independent of EN.
  - Entry stored: {MODE, CMD, OPA, OPB, CIN, IN_VALID, tag}.
  - The tag counter increments on push and wraps modulo 2^TAG_WIDTH.
- REQ_READY = !full. There is no bypass: pop does not free a slot for a same-cycle push when full.
- Multiply: MODE=1 and CMD ∈ {9, 10}.
- Issue (pop) at a rising edge requires all of: EN=1, FIFO non-empty, bubble flag clear.
  - ALU_* registers load the head entry.
  - If the entry is a multiply, set the bubble flag.
- Idle slot: any EN=1 edge without issue, including the bubble slot.
  - ALU_* load the no-op: MODE=1, CMD=0, IN_VALID=2'b00, operands 0, CIN 0.
  - The bubble flag clears on the bubble slot.
- ALU latency contract, counted in EN=1 edges after the issue edge k:
  - non-multiply RESULT/flags are new after edge k+2;
  - multiply RESULT is new after edge k+3.
- Result tracker: 3 slots T1..T3, each {valid, tag}.
  - On every EN=1 edge: T1←T2, T2←T3, T3←0, RES_VALID←T1.valid, RES_TAG←T1.tag.
  - On an issue edge the issued tag is written into T2 (non-multiply) or T3 (multiply), overriding the shift.
  - Invariant: a non-multiply issue never finds T3 valid; the bubble guarantees this. The bench asserts it.
- EN=0 edge:
  - no issue, tracker frozen, ALU_* hold, RES_VALID←0;
  - pushes still accepted.
- BUSY = !empty | T1/T2/T3 valid | RES_VALID.
- IN_VALID=00 requests are issued unmodified and tracked as non-multiply.

## Timing
- Reset values:
  - REQ_READY 1 and ACC_TAG 0 (combinational, from an empty FIFO and a cleared counter);
  - ALU_MODE 1; all other ALU_* 0;
  - RES_VALID 0, RES_TAG 0, BUSY 0.
- Reset clears the FIFO, tag counter, bubble flag and tracker. Requests and results in flight at reset are dropped and never reported.
- Push at edge p into an empty FIFO: earliest issue is edge p+1. RES_VALID is then high in the cycle after edge p+3 (non-multiply) or p+4 (multiply).
- Back-to-back non-multiplies issue on consecutive EN edges and produce back-to-back RES_VALID.
- Multiply at edge k: the next issue is no earlier than edge k+2.
- Full FIFO: REQ_READY=0 for the whole cycle, even if a pop occurs at the edge that ends it.

## Test plan
- ADD 3+4 (MODE1, CMD0, IN_VALID 11) pushed at edge 0 -> issue at edge 1; RES_VALID=1, RES_TAG=0 after edge 3, coinciding with RESULT=7.
- MUL1 (A=2, B=3) then ADD, queued back-to-back -> MUL issues at edge n, idle slot at n+1, ADD at n+2. RES_VALID tags 0 then 1 after edges n+3 and n+4; never two in one cycle.
- Hold REQ_VALID=1 with EN=0 -> exactly 4 pushes accepted, REQ_READY=0 afterwards, ALU_CE=0, no RES_VALID. After EN=1, 4 results arrive in tag order 0..3.
- Drop EN for 2 cycles with 2 results in flight -> RES_VALID pulses resume after EN returns, each exactly once, with tags preserved.
- Push 20 requests -> RES_TAG sequence 0..15, 0..3 (tag wrap).
- Assert RESET one cycle after a multiply issues -> all outputs at reset values; no RES_VALID for that tag after reset releases; ACC_TAG restarts at 0.
